feature_buffer_responder: RTL and testbench
===========================================

# feature_buffer_responder

Responder end of the 512-bit feature-buffer protocol driven by the `mm` compute engine. It services streamed read requests on the input-address port and writes on the output-address/data port. It returns read data after a fixed, parameterised latency with no backpressure. A host port loads and unloads the same storage in the cycles the engine leaves free.

## Interface
- DATA_W, 512, word width
- ADDR_W, 11, address width
- DEPTH, 2048, words stored (≤ 2^ADDR_W)
- RD_LAT, 2, read latency in cycles, legal 1..4

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_addr_valid  in  1  engine read request
- input_addr  in  ADDR_W  engine read address
- input_data_valid  out  1  engine read data valid
- input_data  out  DATA_W  engine read data
- output_addr_valid  in  1  engine write address valid
- output_addr  in  ADDR_W  engine write address
- output_data_valid  in  1  engine write data valid
- output_data  in  DATA_W  engine write data
- host_wr_en  in  1  host write request
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  DATA_W  host write data
- host_wr_ready  out  1  host write accepted this cycle
- host_rd_en  in  1  host read request
- host_rd_addr  in  ADDR_W  host read address
- host_rd_ready  out  1  host read accepted this cycle
- host_rd_valid  out  1  host read data valid
- host_rd_data  out  DATA_W  host read data
- rd_count  out  16  engine reads accepted, saturating
- wr_count  out  16  engine writes accepted, saturating
- err  out  1  sticky protocol/range error

## Operation
- Storage is DEPTH×DATA_W with one read port and one write port per cycle. Contents are not cleared by rst.
- Read arbitration: the engine always wins. `host_rd_ready = !input_addr_valid`, combinational. A host read is accepted when `host_rd_en && host_rd_ready`.
- Write arbitration: an engine write occurs when `output_addr_valid && output_data_valid`. That write always wins. `host_wr_ready = !(output_addr_valid && output_data_valid)`, combinational. A host write is accepted when `host_wr_en && host_wr_ready`.
- Protocol check: `output_addr_valid != output_data_valid` in any cycle sets err. No write occurs in that cycle, and the host write is allowed.
- Range check: any accepted read or write with address ≥ DEPTH sets err. Such a write is dropped. Such a read still returns a valid beat with data 0.
- Read/write collision, same cycle and same address: the read returns the newly written data (write-first). This applies to any read/write source pairing.
- Read pipeline: RD_LAT-deep shift of {valid, source, data}. The source bit routes each beat to either the input_data pair or the host_rd pair. Only the selected pair's valid asserts. When its valid is low, a data output holds its last value.
- rd_count increments per accepted engine read. wr_count increments per engine write. Both saturate at 0xFFFF.
- err clears only on rst.
- No state machine beyond the pipeline. Back-to-back requests are accepted every cycle indefinitely.

## Timing
- Read accepted at edge t → data valid for exactly one cycle after edge t+RD_LAT. Throughput is 1 read/cycle.
- Write accepted at edge t → visible to a read accepted at edge t (forwarded) and to all later reads.
- Ready outputs are combinational from the current-cycle engine valids. There is no registered stall.
- rst in the cycle of edge t (sync): after edge t the following hold until the next accepted request:
  - all pipeline valids are 0
  - input_data_valid, host_rd_valid, err, rd_count and wr_count are 0
  - input_data and host_rd_data are 0
- In-flight reads at rst are discarded and never return.
- Requests presented while rst is high are ignored: no write, no count, no beat.
- RD_LAT=1: the output register is directly after the memory read.
- RD_LAT>1: extra register stages follow the memory read.

## Test plan
- Host writes addr 5=A, 6=B, then engine reads 5,6 back-to-back → input_data A at t+2 and B at t+3 (RD_LAT=2). rd_count=2, host_rd_valid stays 0.
- Engine reads addr 9 while host_rd_en on addr 9 in the same cycle → host_rd_ready=0, engine gets data. Host retries next cycle and receives data at t+3.
- Engine write addr 3=C plus engine read addr 3 in the same cycle → read returns C. Host write in the same cycle gets host_wr_ready=0 and addr unchanged.
- output_addr_valid=1 with output_data_valid=0 → err=1, memory unchanged, wr_count unchanged. err persists until rst.
- Read addr 2047 (DEPTH=2048) is normal. Read with DEPTH=1024 at addr 1500 → beat with data 0, err=1.
- Issue 4 reads, assert rst one cycle after the first accept → no input_data_valid afterward, all outputs and counters 0. Memory contents are preserved on re-read.

Source files
------------

// File: rtl/feature_buffer_responder_if.sv
// -----------------------------------------------------------------------------
// feature_buffer_responder_if
//   Bundles the engine read/write request lines, the host load/unload port and
//   the status outputs of the feature-buffer responder.
//
//   Engine side : input_addr_valid/input_addr  -> input_data_valid/input_data
//                 output_addr_valid/output_addr + output_data_valid/output_data
//   Host side   : host_wr_en/addr/data -> host_wr_ready
//                 host_rd_en/addr      -> host_rd_ready, host_rd_valid/data
//   Status      : rd_count, wr_count (saturating), err (sticky)
//
//   Modports: slave  = the responder, master = engine + host driver.
// -----------------------------------------------------------------------------
interface feature_buffer_responder_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 11
);
    logic              input_addr_valid;
    logic [ADDR_W-1:0] input_addr;
    logic              input_data_valid;
    logic [DATA_W-1:0] input_data;
    logic              output_addr_valid;
    logic [ADDR_W-1:0] output_addr;
    logic              output_data_valid;
    logic [DATA_W-1:0] output_data;
    logic              host_wr_en;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_ready;
    logic              host_rd_en;
    logic [ADDR_W-1:0] host_rd_addr;
    logic              host_rd_ready;
    logic              host_rd_valid;
    logic [DATA_W-1:0] host_rd_data;
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;
    logic              err;

    modport slave (
        input  input_addr_valid, input_addr,
        input  output_addr_valid, output_addr, output_data_valid, output_data,
        input  host_wr_en, host_wr_addr, host_wr_data,
        input  host_rd_en, host_rd_addr,
        output input_data_valid, input_data,
        output host_wr_ready, host_rd_ready, host_rd_valid, host_rd_data,
        output rd_count, wr_count, err
    );

    modport master (
        output input_addr_valid, input_addr,
        output output_addr_valid, output_addr, output_data_valid, output_data,
        output host_wr_en, host_wr_addr, host_wr_data,
        output host_rd_en, host_rd_addr,
        input  input_data_valid, input_data,
        input  host_wr_ready, host_rd_ready, host_rd_valid, host_rd_data,
        input  rd_count, wr_count, err
    );
endinterface

// File: rtl/feature_buffer_responder.sv
// -----------------------------------------------------------------------------
// feature_buffer_responder
//   Responder end of the feature-buffer protocol. A DEPTH x DATA_W store with
//   one read and one write per cycle, shared between the compute engine (which
//   always wins arbitration) and a host load/unload port. Reads return after
//   RD_LAT cycles (legal 1..4) with no backpressure; a same-cycle write to the
//   read address is forwarded (write-first).
//
//   Ports:
//     clk  - single rising-edge clock
//     rst  - synchronous, active-high reset (storage contents are kept)
//     bus  - feature_buffer_responder_if.slave (engine, host and status lines)
// -----------------------------------------------------------------------------
module feature_buffer_responder #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    feature_buffer_responder_if.slave bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic { SRC_ENGINE = 1'b0, SRC_HOST = 1'b1 } src_e;

    typedef struct packed {
        logic              valid;
        src_e              src;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              eng_wr, proto_err, wr_req, wr_oob, wr_en_mem;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              eng_rd, rd_req, rd_oob;
    logic [ADDR_W-1:0] rd_addr;
    beat_t             rd_beat;
    beat_t             stage_q [RD_LAT];
    beat_t             last;

    logic              in_valid_q, in_valid_d, hr_valid_q, hr_valid_d;
    logic [DATA_W-1:0] in_data_q, in_data_d, hr_data_q, hr_data_d;
    logic [15:0]       rd_count_q, rd_count_d, wr_count_q, wr_count_d;
    logic              err_q, err_d;

    // Request decode and arbitration. Requests seen during rst are ignored.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eng_wr    = bus.output_addr_valid && bus.output_data_valid;
        proto_err = bus.output_addr_valid != bus.output_data_valid;
        wr_req    = !rst && (eng_wr || bus.host_wr_en);
        wr_addr   = eng_wr ? bus.output_addr : bus.host_wr_addr;
        wr_data   = eng_wr ? bus.output_data : bus.host_wr_data;
        wr_oob    = {1'b0, wr_addr} >= DEPTH_L;
        wr_en_mem = wr_req && !wr_oob;

        eng_rd    = !rst && bus.input_addr_valid;
        rd_req    = eng_rd || (!rst && bus.host_rd_en);
        rd_addr   = bus.input_addr_valid ? bus.input_addr : bus.host_rd_addr;
        rd_oob    = {1'b0, rd_addr} >= DEPTH_L;

        rd_beat.valid = rd_req;
        rd_beat.src   = bus.input_addr_valid ? SRC_ENGINE : SRC_HOST;
        if (rd_oob)
            rd_beat.data = '0;
        else if (wr_en_mem && (wr_addr == rd_addr))
            rd_beat.data = wr_data;          // write-first forwarding
        else
            rd_beat.data = mem_q[rd_addr[IDX_W-1:0]];
    end

    // NOTE: the storage array has no reset; contents survive rst and map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en_mem)
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // Read pipeline: stage 0 is the registered memory read, the last stage
    // feeds the routed output registers. Only the valids need clearing.
    // NOTE: state is updated with <= so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++)
                stage_q[i].valid <= 1'b0;
        end else begin
            stage_q[0] <= rd_beat;
            for (int i = 1; i < RD_LAT; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign last = stage_q[RD_LAT-1];

    always_comb begin
        in_valid_d = 1'b0;
        hr_valid_d = 1'b0;
        in_data_d  = in_data_q;              // data outputs hold between beats
        hr_data_d  = hr_data_q;
        if (last.valid) begin
            if (last.src == SRC_ENGINE) begin
                in_valid_d = 1'b1;
                in_data_d  = last.data;
            end else begin
                hr_valid_d = 1'b1;
                hr_data_d  = last.data;
            end
        end

        rd_count_d = rd_count_q;
        if (eng_rd && (rd_count_q != 16'hFFFF))
            rd_count_d = rd_count_q + 16'd1;
        wr_count_d = wr_count_q;
        if (!rst && eng_wr && (wr_count_q != 16'hFFFF))
            wr_count_d = wr_count_q + 16'd1;

        err_d = err_q || (!rst && (proto_err || (wr_req && wr_oob) || (rd_req && rd_oob)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            hr_valid_q <= 1'b0;
            in_data_q  <= '0;
            hr_data_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            in_valid_q <= in_valid_d;
            hr_valid_q <= hr_valid_d;
            in_data_q  <= in_data_d;
            hr_data_q  <= hr_data_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
        end
    end

    // Readies depend only on the current-cycle engine valids.
    assign bus.host_rd_ready    = !bus.input_addr_valid;
    assign bus.host_wr_ready    = !eng_wr;
    assign bus.input_data_valid = in_valid_q;
    assign bus.input_data       = in_data_q;
    assign bus.host_rd_valid    = hr_valid_q;
    assign bus.host_rd_data     = hr_data_q;
    assign bus.rd_count         = rd_count_q;
    assign bus.wr_count         = wr_count_q;
    assign bus.err              = err_q;
endmodule

// File: tb/tb_feature_buffer_responder.sv
// -----------------------------------------------------------------------------
// tb_feature_buffer_responder
//   Directed scenarios followed by randomized traffic against a transaction
//   model (associative-array memory, queue of expected beats with due edges).
//   A second, smaller instance (DEPTH=1024) covers the out-of-range read.
// -----------------------------------------------------------------------------
module tb_feature_buffer_responder;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
    localparam int RD_LAT = 2;
    localparam int DEPTH_S = 1024;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    always #5 clk = ~clk;

    feature_buffer_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    feature_buffer_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sb ();

    feature_buffer_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT))
        dut (.clk(clk), .rst(rst), .bus(bus));
    feature_buffer_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH_S), .RD_LAT(RD_LAT))
        dut_small (.clk(clk), .rst(rst_s), .bus(sb));

    typedef struct {
        int                due;
        bit                host;
        logic [DATA_W-1:0] data;
    } exp_beat_t;

    logic [DATA_W-1:0] m_mem [int];
    exp_beat_t         m_q [$];
    int                m_rd, m_wr;
    logic              m_err;
    logic [DATA_W-1:0] m_in_data, m_hr_data;
    int                edge_n = 0;
    int                compared = 0;
    int                mismatched = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] pick_addr();
        int r = $urandom_range(0, 16);
        return (r == 16) ? ADDR_W'(DEPTH - 1) : ADDR_W'(r);
    endfunction

    task automatic idle();
        bus.input_addr_valid = 0;  bus.input_addr = '0;
        bus.output_addr_valid = 0; bus.output_addr = '0;
        bus.output_data_valid = 0; bus.output_data = '0;
        bus.host_wr_en = 0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
        bus.host_rd_en = 0; bus.host_rd_addr = '0;
    endtask

    // Apply the spec's rules to the current inputs, step one edge, then
    // compare every output of the main instance against the model.
    task automatic cycle();
        exp_beat_t b;
        logic exp_iv, exp_hv;
        int a;
        #1;
        check("host_rd_ready", bus.host_rd_ready, !bus.input_addr_valid);
        check("host_wr_ready", bus.host_wr_ready, !(bus.output_addr_valid && bus.output_data_valid));
        if (rst) begin
            m_q.delete();
            m_rd = 0; m_wr = 0; m_err = 0;
            m_in_data = '0; m_hr_data = '0;
        end else begin
            if (bus.output_addr_valid != bus.output_data_valid) m_err = 1;
            if (bus.output_addr_valid && bus.output_data_valid) begin
                if (m_wr < 65535) m_wr++;
                m_mem[int'(bus.output_addr)] = bus.output_data;
            end else if (bus.host_wr_en) begin
                m_mem[int'(bus.host_wr_addr)] = bus.host_wr_data;
            end
            if (bus.input_addr_valid || bus.host_rd_en) begin
                b.host = !bus.input_addr_valid;
                a = b.host ? int'(bus.host_rd_addr) : int'(bus.input_addr);
                if (!b.host && m_rd < 65535) m_rd++;
                b.due  = edge_n + RD_LAT;
                b.data = m_mem.exists(a) ? m_mem[a] : 'x;
                m_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        exp_iv = 0;
        exp_hv = 0;
        if (m_q.size() > 0 && m_q[0].due == edge_n) begin
            b = m_q.pop_front();
            if (b.host) begin exp_hv = 1; m_hr_data = b.data; end
            else        begin exp_iv = 1; m_in_data = b.data; end
        end
        check("input_data_valid", bus.input_data_valid, exp_iv);
        check("input_data",       bus.input_data,       m_in_data);
        check("host_rd_valid",    bus.host_rd_valid,    exp_hv);
        check("host_rd_data",     bus.host_rd_data,     m_hr_data);
        check("rd_count",         bus.rd_count,         m_rd);
        check("wr_count",         bus.wr_count,         m_wr);
        check("err",              bus.err,              m_err);
        edge_n++;
    endtask

    task automatic small_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] va, vb, vc, vd, vs;
        int r;
        idle();
        sb.input_addr_valid = 0;  sb.input_addr = '0;
        sb.output_addr_valid = 0; sb.output_addr = '0;
        sb.output_data_valid = 0; sb.output_data = '0;
        sb.host_wr_en = 0; sb.host_wr_addr = '0; sb.host_wr_data = '0;
        sb.host_rd_en = 0; sb.host_rd_addr = '0;
        rst = 1; rst_s = 1;

        // Reset, then preload the address pool through the host port.
        cycle(); cycle();
        rst = 0; rst_s = 0;
        for (int i = 0; i <= 16; i++) begin
            bus.host_wr_en = 1;
            bus.host_wr_addr = (i == 16) ? ADDR_W'(DEPTH - 1) : ADDR_W'(i);
            bus.host_wr_data = rand_word();
            cycle();
        end
        idle();

        // Host writes 5/6, engine reads them back-to-back.
        va = rand_word(); vb = rand_word();
        bus.host_wr_en = 1; bus.host_wr_addr = 5; bus.host_wr_data = va; cycle();
        bus.host_wr_addr = 6; bus.host_wr_data = vb; cycle();
        idle();
        bus.input_addr_valid = 1; bus.input_addr = 5; cycle();
        bus.input_addr = 6; cycle();
        idle(); cycle(); cycle(); cycle();
        check("rd_count_after_pair", bus.rd_count, 2);

        // Engine and host read addr 9 together; host retries next cycle.
        bus.input_addr_valid = 1; bus.input_addr = 9;
        bus.host_rd_en = 1; bus.host_rd_addr = 9; cycle();
        bus.input_addr_valid = 0; cycle();
        idle(); cycle(); cycle(); cycle();

        // Engine write + engine read + host write, all to addr 3.
        vc = rand_word(); vd = rand_word();
        bus.output_addr_valid = 1; bus.output_data_valid = 1;
        bus.output_addr = 3; bus.output_data = vc;
        bus.input_addr_valid = 1; bus.input_addr = 3;
        bus.host_wr_en = 1; bus.host_wr_addr = 3; bus.host_wr_data = vd;
        cycle();
        idle();
        bus.host_rd_en = 1; bus.host_rd_addr = 3; cycle();
        idle(); cycle(); cycle(); cycle();
        check("addr3_keeps_engine_data", bus.host_rd_data, vc);

        // Address without data: err, no write, no count.
        bus.output_addr_valid = 1; bus.output_addr = 4; bus.output_data = rand_word(); cycle();
        idle();
        bus.input_addr_valid = 1; bus.input_addr = 4; cycle();
        bus.input_addr = ADDR_W'(DEPTH - 1); cycle();
        idle(); cycle(); cycle(); cycle(); cycle();

        // Four reads, rst asserted from the cycle after the first accept.
        for (int i = 0; i < 4; i++) begin
            bus.input_addr_valid = 1; bus.input_addr = ADDR_W'(i + 10);
            rst = (i > 0);
            cycle();
        end
        rst = 0; idle();
        for (int i = 0; i < 4; i++) cycle();
        bus.input_addr_valid = 1; bus.input_addr = 5; cycle();
        idle(); cycle(); cycle();
        check("preserved_after_rst", bus.input_data, va);

        // Random traffic: first without protocol errors, then with.
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 300; n++) begin
                bus.input_addr_valid = 1'($urandom_range(0, 1));
                bus.input_addr = pick_addr();
                r = $urandom_range(0, 7);
                bus.output_addr_valid = (r < 3) || (phase == 1 && r == 7);
                bus.output_data_valid = (r < 3) || (phase == 1 && r == 6);
                bus.output_addr = pick_addr();
                bus.output_data = rand_word();
                bus.host_wr_en = 1'($urandom_range(0, 1));
                bus.host_wr_addr = pick_addr();
                bus.host_wr_data = rand_word();
                bus.host_rd_en = 1'($urandom_range(0, 1));
                bus.host_rd_addr = pick_addr();
                rst = ($urandom_range(0, 59) == 0);
                cycle();
            end
            rst = 0; idle();
            cycle(); cycle(); cycle();
        end

        // Small instance: last in-range address, then an out-of-range read.
        vs = rand_word();
        sb.host_wr_en = 1; sb.host_wr_addr = 11'd1023; sb.host_wr_data = vs; small_step();
        sb.host_wr_en = 0;
        sb.input_addr_valid = 1; sb.input_addr = 11'd1023; small_step();
        check("small_err_in_range", sb.err, 1'b0);
        sb.input_addr = 11'd1500; small_step();
        sb.input_addr_valid = 0;
        check("small_err_oob", sb.err, 1'b1);
        small_step();
        check("small_valid_1023", sb.input_data_valid, 1'b1);
        check("small_data_1023", sb.input_data, vs);
        small_step();
        check("small_valid_oob", sb.input_data_valid, 1'b1);
        check("small_data_oob", sb.input_data, '0);
        small_step();
        check("small_valid_idle", sb.input_data_valid, 1'b0);
        check("small_data_hold", sb.input_data, '0);
        check("small_host_rd_valid", sb.host_rd_valid, 1'b0);
        check("small_rd_count", sb.rd_count, 16'd2);
        check("small_err_sticky", sb.err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
